// File: rtl/vga_scan_out.sv
// VGA raster scan generator: pixel-rate divider, h/v counters, and a registered
// sync/colour stage that lags the counters by exactly one pixel period.
module vga_scan_out #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] red_in,
    input  logic [3:0] green_in,
    input  logic [3:0] blue_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       frame_start,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic       HS_ON    = 1'(HS_POL);
    localparam logic       VS_ON    = 1'(VS_POL);

    logic [DIV_W-1:0] div_cnt;
    logic             pix_en;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             hs_zone;
    logic             vs_zone;

    assign pix_en = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (pix_en) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Stage 0: raster position, advanced once per pixel period
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign x           = h_cnt;
    assign y           = v_cnt;
    assign active      = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign frame_start = pix_en && (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign hs_zone     = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    assign vs_zone     = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

    // Stage 1: DAC/sync registers, one pixel behind the counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= ~HS_ON;
            vga_vs <= ~VS_ON;
        end else if (pix_en) begin
            vga_r  <= active ? red_in   : 4'h0;
            vga_g  <= active ? green_in : 4'h0;
            vga_b  <= active ? blue_in  : 4'h0;
            vga_hs <= hs_zone ? HS_ON : ~HS_ON;
            vga_vs <= vs_zone ? VS_ON : ~VS_ON;
        end
    end

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out on a shrunken raster; expectations come from an
// absolute-time model (pixel index = clocks since reset / CLK_DIV).
module tb_vga_scan_out;

    localparam int CD  = 2;
    localparam int HV  = 20, HFP = 2, HSY = 3, HBP = 4;
    localparam int VV  = 10, VFP = 1, VSY = 2, VBP = 3;
    localparam int HT  = HV + HFP + HSY + HBP;
    localparam int VT  = VV + VFP + VSY + VBP;
    localparam int HS_START = HV + HFP;
    localparam int VS_START = VV + VFP;
    localparam int FRAME = HT * VT * CD;
    localparam logic [35:0] RST_VEC = {10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] red_in, green_in, blue_in;
    logic [9:0] x, y;
    logic       active, frame_start, vga_hs, vga_vs;
    logic [3:0] vga_r, vga_g, vga_b;
    logic [35:0] obs;

    int errors = 0;
    int checks = 0;
    int n = 0;
    int mode = 0;
    int seed = 0;

    vga_scan_out #(
        .CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .HS_POL(0), .VS_POL(0)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .x(x), .y(y), .active(active), .frame_start(frame_start),
        .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] col(input int h, input int v, input int md, input int sd);
        int tmp;
        tmp = h * 5 + v * 11 + sd;
        case (md)
            1:       return 12'hA5F;
            2:       return (h == 5 && v == 7) ? 12'h300 : 12'h000;
            default: return tmp[11:0];
        endcase
    endfunction

    always_comb {red_in, green_in, blue_in} = col(int'(x), int'(y), mode, seed);
    assign obs = {x, y, active, frame_start, vga_hs, vga_vs, vga_r, vga_g, vga_b};

    // Expected observable vector after nn rising edges since reset release
    function automatic logic [35:0] model(input int nn);
        int p, h, v, q, hq, vq;
        logic act, fs, hs, vs;
        logic [11:0] c;
        p   = nn / CD;
        h   = p % HT;
        v   = (p / HT) % VT;
        act = (h < HV) && (v < VV);
        fs  = (nn % CD == CD - 1) && (h == HT - 1) && (v == VT - 1);
        if (p == 0) begin
            c = 12'h000; hs = 1'b1; vs = 1'b1;
        end else begin
            q  = p - 1;
            hq = q % HT;
            vq = (q / HT) % VT;
            c  = (hq < HV && vq < VV) ? col(hq, vq, mode, seed) : 12'h000;
            hs = !(hq >= HS_START && hq < HS_START + HSY);
            vs = !(vq >= VS_START && vq < VS_START + VSY);
        end
        return {10'(h), 10'(v), act, fs, hs, vs, c};
    endfunction

    task automatic step();
        @(posedge clk);
        n = n + 1;
        @(negedge clk);
    endtask

    task automatic start(input int md);
        mode = md;
        seed = int'($urandom_range(0, 4095));
        @(negedge clk);
        reset_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset_n = 1'b1;
        n = 0;
    endtask

    task automatic test_reset();
        mode = 0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 checks++;
        if (obs !== RST_VEC) begin
            errors++; $display("FAIL reset_async got %h required %h", obs, RST_VEC);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== RST_VEC) begin
                errors++; $display("FAIL reset_hold got %h required %h", obs, RST_VEC);
            end
        end
        reset_n = 1'b1;
        n = 0;
        step();
        checks++;
        if (x !== 10'd0 || vga_hs !== 1'b1 || vga_vs !== 1'b1 || {vga_r, vga_g, vga_b} !== 12'h0) begin
            errors++; $display("FAIL release_edge1 got x=%0d hs=%b vs=%b rgb=%h required x=0 hs=1 vs=1 rgb=000",
                               x, vga_hs, vga_vs, {vga_r, vga_g, vga_b});
        end
        step();
        checks++;
        if (x !== 10'd1 || y !== 10'd0) begin
            errors++; $display("FAIL release_edge2 got x=%0d y=%0d required x=1 y=0", x, y);
        end
    endtask

    task automatic test_scan();
        int bad = 0;
        int first_n = -1;
        logic [35:0] got, exp;
        start(0);
        for (int i = 0; i < 2 * FRAME + 50; i++) begin
            step();
            if (obs !== model(n)) begin
                if (bad == 0) begin first_n = n; got = obs; exp = model(n); end
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL scan_random bad_cycles=%0d required 0 (first n=%0d got %h required %h)",
                               bad, first_n, got, exp);
        end
    endtask

    task automatic test_hsync();
        int falls[$];
        int fall_x[$];
        int runs[$];
        int run = 0;
        logic prev = 1'b1;
        start(0);
        for (int i = 0; i < 4 * HT * CD; i++) begin
            step();
            if (vga_hs === 1'b0) run++;
            if (prev === 1'b1 && vga_hs === 1'b0) begin falls.push_back(n); fall_x.push_back(int'(x)); end
            if (prev === 1'b0 && vga_hs === 1'b1) begin runs.push_back(run); run = 0; end
            prev = vga_hs;
        end
        checks++;
        if (falls.size() != 4 || runs.size() < 3) begin
            errors++; $display("FAIL hs_edges got falls=%0d runs=%0d required 4 and >=3", falls.size(), runs.size());
        end
        foreach (runs[i]) begin
            checks++;
            if (runs[i] != HSY * CD) begin
                errors++; $display("FAIL hs_width got %0d required %0d", runs[i], HSY * CD);
            end
        end
        foreach (fall_x[i]) begin
            checks++;
            if (fall_x[i] != HS_START + 1) begin
                errors++; $display("FAIL hs_start_x got %0d required %0d", fall_x[i], HS_START + 1);
            end
        end
        for (int i = 1; i < falls.size(); i++) begin
            checks++;
            if (falls[i] - falls[i-1] != HT * CD) begin
                errors++; $display("FAIL line_period got %0d required %0d", falls[i] - falls[i-1], HT * CD);
            end
        end
    endtask

    task automatic test_vsync_frame();
        int fs_at[$];
        int vs_runs[$];
        int run = 0;
        int width = 0;
        int max_width = 0;
        logic prev = 1'b1;
        start(0);
        for (int i = 0; i < 2 * FRAME + 20; i++) begin
            step();
            if (vga_vs === 1'b0) run++;
            if (prev === 1'b0 && vga_vs === 1'b1) begin vs_runs.push_back(run); run = 0; end
            prev = vga_vs;
            if (frame_start === 1'b1) begin
                if (width == 0) fs_at.push_back(n);
                width++;
                if (width > max_width) max_width = width;
            end else begin
                width = 0;
            end
        end
        checks++;
        if (vs_runs.size() != 2 || fs_at.size() != 2) begin
            errors++; $display("FAIL vs_fs_count got vs=%0d fs=%0d required 2 and 2", vs_runs.size(), fs_at.size());
        end
        foreach (vs_runs[i]) begin
            checks++;
            if (vs_runs[i] != VSY * HT * CD) begin
                errors++; $display("FAIL vs_width got %0d required %0d", vs_runs[i], VSY * HT * CD);
            end
        end
        checks++;
        if (max_width != 1) begin
            errors++; $display("FAIL fs_width got %0d required 1", max_width);
        end
        if (fs_at.size() >= 2) begin
            checks++;
            if (fs_at[0] != FRAME - 1 || fs_at[1] - fs_at[0] != FRAME) begin
                errors++; $display("FAIL fs_timing got first=%0d gap=%0d required first=%0d gap=%0d",
                                   fs_at[0], fs_at[1] - fs_at[0], FRAME - 1, FRAME);
            end
        end
    endtask

    task automatic test_const_colour();
        int vis = 0;
        int other = 0;
        int blank_bad = 0;
        start(1);
        for (int i = 0; i < FRAME + CD - 1; i++) begin
            step();
            if ({vga_r, vga_g, vga_b} === 12'hA5F) vis++;
            else if ({vga_r, vga_g, vga_b} !== 12'h000) other++;
            if (model(n) != model(n) || (model(n) & 36'hFFF) != {24'h0, vga_r, vga_g, vga_b}) blank_bad++;
        end
        checks++;
        if (vis != HV * VV * CD || other != 0) begin
            errors++; $display("FAIL const_colour got vis=%0d other=%0d required vis=%0d other=0", vis, other, HV * VV * CD);
        end
        checks++;
        if (blank_bad != 0) begin
            errors++; $display("FAIL const_blanking bad_cycles=%0d required 0", blank_bad);
        end
    endtask

    task automatic test_single_pixel();
        int hits = 0;
        int hx = -1, hy = -1;
        start(2);
        for (int i = 0; i < FRAME + CD; i++) begin
            step();
            if (vga_r === 4'h3) begin
                if (hits == 0) begin hx = int'(x); hy = int'(y); end
                hits++;
            end
        end
        checks++;
        if (hits != CD || hx != 6 || hy != 7) begin
            errors++; $display("FAIL single_pixel got clks=%0d at x=%0d y=%0d required clks=%0d at x=6 y=7",
                               hits, hx, hy, CD);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        int fs_cnt = 0;
        int fs_n = -1;
        start(0);
        while (n < (5 * HT + 10) * CD) step();
        checks++;
        if (x !== 10'd10 || y !== 10'd5) begin
            errors++; $display("FAIL mid_position got x=%0d y=%0d required x=10 y=5", x, y);
        end
        #2 reset_n = 1'b0;
        #1 checks++;
        if (obs !== RST_VEC) begin
            errors++; $display("FAIL mid_reset_async got %h required %h", obs, RST_VEC);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (obs !== RST_VEC) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL mid_reset_hold bad_cycles=%0d required 0", bad);
        end
        reset_n = 1'b1;
        n = 0;
        bad = 0;
        for (int i = 0; i < FRAME + 10; i++) begin
            step();
            if (obs !== model(n)) bad++;
            if (frame_start === 1'b1) begin fs_cnt++; fs_n = n; end
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL mid_rescan bad_cycles=%0d required 0", bad);
        end
        checks++;
        if (fs_cnt != 1 || fs_n != FRAME - 1) begin
            errors++; $display("FAIL mid_frame_start got count=%0d at n=%0d required count=1 at n=%0d",
                               fs_cnt, fs_n, FRAME - 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_scan();
        test_hsync();
        test_vsync_frame();
        test_const_colour();
        test_single_pixel();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_scan_out.md
VGA_SCAN_OUT -- requirements
Module: vga_scan_out

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 2, system clocks per pixel (1..4).
REQ-002 SHALL provide parameters H_VISIBLE 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal timing in pixels.
REQ-003 SHALL provide parameters V_VISIBLE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical timing in lines.
REQ-004 SHALL provide parameters HS_POL 0 and VS_POL 0: asserted sync level, 0 meaning active-low.
REQ-005 clk  in  1  system clock; one clock domain, all state on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 red_in, green_in, blue_in  in  4 each  pixel colour from game/colour logic for current x,y.
REQ-008 x  out  10  current horizontal count (h_cnt).
REQ-009 y  out  10  current vertical count (v_cnt).
REQ-010 active  out  1  high when x < H_VISIBLE and y < V_VISIBLE.
REQ-011 frame_start  out  1  one-clk pulse on wrap to (0,0).
REQ-012 vga_hs, vga_vs  out  1 each  registered sync outputs.
REQ-013 vga_r, vga_g, vga_b  out  4 each  registered colour to DAC.

Function
REQ-014 Divider div_cnt SHALL count 0..CLK_DIV-1 and wrap; pix_en = (div_cnt == CLK_DIV-1); CLK_DIV=1 gives pix_en every clk.
REQ-015 H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
REQ-016 On pix_en, h_cnt SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and v_cnt SHALL increment in the same cycle.
REQ-017 v_cnt SHALL wrap to 0 when h_cnt and v_cnt both wrap; counters SHALL hold between pix_en pulses.
REQ-018 x, y, active SHALL be driven directly from the counter registers (no added latency).
REQ-019 frame_start SHALL be 1 for exactly the clk where pix_en=1, h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1; else 0.
REQ-020 On pix_en, vga_r/g/b SHALL load colour inputs if active else 0 (forced blanking, inputs ignored).
REQ-021 On pix_en, vga_hs SHALL load HS_POL when h_cnt in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] ([656,751]), else ~HS_POL.
REQ-022 On pix_en, vga_vs SHALL load VS_POL when v_cnt in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1] ([490,491]), else ~VS_POL.
REQ-023 Output latency: vga_* SHALL reflect the counter value of the previous pixel period, one pixel period after x,y; colour source SHALL be combinational from x,y within one pixel period.
REQ-024 Outputs vga_* SHALL change only on clk edges where pix_en=1.

Reset
REQ-025 reset_n low SHALL immediately clear div_cnt, h_cnt, v_cnt to 0 irrespective of clk.
REQ-026 During reset: vga_r/g/b=0, vga_hs=~HS_POL, vga_vs=~VS_POL, frame_start=0, x=y=0, active=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame; after release, scan SHALL restart at (0,0) with first pix_en on clk CLK_DIV.
REQ-028 No frame_start SHALL be emitted because of reset entry or exit.

Verification
REQ-029 Reset release, CLK_DIV=2 -> x=0 for 2 clks, x=1 after 2nd edge; vga_hs=1, vga_vs=1, colour 0.
REQ-030 Free run one line -> vga_hs low for exactly 192 clks, beginning one pixel after h_cnt=656; line period 1600 clks.
REQ-031 Free run full frame -> vga_vs low for 2 lines (3200 clks); frame_start pulses exactly 840000 clks apart, width 1 clk.
REQ-032 red_in=0xA,green_in=0x5,blue_in=0xF constant -> vga_rgb=A/5/F for visible pixels, 0/0/0 for h_cnt 640..799 and v_cnt 480..524.
REQ-033 Colour = 0x3 only at x=5,y=7 -> vga_r=0x3 for exactly one pixel period, starting one pixel after x=5.
REQ-034 Assert reset_n at x=300,y=200 for 3 clks -> all outputs at reset values asynchronously; rescan from (0,0), no spurious frame_start.
